line_walker: RTL

- Generates the pixel coordinates along a line segment (x0,y0)->(x1,y1) using Bresenham stepping.
- Emits one (x,y) per accepted handshake, feeding the pixel writer.
- It is the generator counterpart of line_finder: line_finder classifies a given point against an edge, while line_walker produces the points that lie on the edge.
- Used by the GPU line/polyline command path.

---
 rtl/line_walker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/line_walker.sv
// Bresenham line generator: walks (x0,y0)->(x1,y1) one pixel per handshake.
// Optional LINE_WALKER_SKIP_LAST_EN drops the endpoint for polyline joints.
module line_walker #(
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               px_last,
    output logic               done
);

    localparam int AW = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WALK
    } state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] cur_x_q, cur_x_d;
    logic [COORD_W-1:0] cur_y_q, cur_y_d;
    logic [COORD_W-1:0] end_x_q, end_x_d;
    logic [COORD_W-1:0] end_y_q, end_y_d;
    logic signed [AW-1:0] dx_q, dx_d;
    logic signed [AW-1:0] dy_q, dy_d;
    logic signed [AW-1:0] err_q, err_d;
    logic sx_q, sx_d;
    logic sy_q, sy_d;
    logic done_q, done_d;

    logic signed [AW-1:0] e2;
    logic signed [AW-1:0] err_step;
    logic step_x, step_y;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic [COORD_W-1:0] abs_x, abs_y;
    logic at_end;
    logic last_c;

    // Candidate next pixel and error term for the current position
    always_comb begin
        e2       = err_q <<< 1;
        step_x   = (e2 >= dy_q);
        step_y   = (e2 <= dx_q);
        nxt_x    = cur_x_q;
        nxt_y    = cur_y_q;
        err_step = err_q;
        if (step_x) begin
            err_step = err_step + dy_q;
            nxt_x    = sx_q ? cur_x_q + ONE : cur_x_q - ONE;
        end
        if (step_y) begin
            err_step = err_step + dx_q;
            nxt_y    = sy_q ? cur_y_q + ONE : cur_y_q - ONE;
        end
        abs_x  = (end_x_q > cur_x_q) ? end_x_q - cur_x_q
                                     : cur_x_q - end_x_q;
        abs_y  = (end_y_q > cur_y_q) ? end_y_q - cur_y_q
                                     : cur_y_q - end_y_q;
        at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
`ifdef LINE_WALKER_SKIP_LAST_EN
        last_c = (nxt_x == end_x_q) && (nxt_y == end_y_q);
`else
        last_c = at_end;
`endif
    end

    // Next-state: capture, setup of Bresenham terms, stepping on handshake
    always_comb begin
        state_d = state_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        end_x_d = end_x_q;
        end_y_d = end_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_x_d = x0;
                    cur_y_d = y0;
                    end_x_d = x1;
                    end_y_d = y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d    = $signed({2'b00, abs_x});
                dy_d    = -$signed({2'b00, abs_y});
                err_d   = $signed({2'b00, abs_x}) - $signed({2'b00, abs_y});
                sx_d    = (cur_x_q < end_x_q);
                sy_d    = (cur_y_q < end_y_q);
                state_d = WALK;
`ifdef LINE_WALKER_SKIP_LAST_EN
                if (at_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`endif
            end
            WALK: begin
                if (px_ready) begin
                    if (last_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_x_d = nxt_x;
                        cur_y_d = nxt_y;
                        err_d   = err_step;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            end_x_q <= '0;
            end_y_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            end_x_q <= end_x_d;
            end_y_q <= end_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign px_valid = (state_q == WALK);
    assign px_last  = (state_q == WALK) && last_c;
    assign px_x     = cur_x_q;
    assign px_y     = cur_y_q;
    assign done     = done_q;

endmodule
